acc_store_unit: RTL and testbench

Write-back path for the accumulator: on a store request it captures the accumulator value and target address, then runs a timed write cycle on the shared 8-bit memory data bus. The write cycle has address/data setup, a write strobe with minimum width and ack wait, data hold, and a completion pulse. It sits between the state controller (which issues start on STO) and the RAM/bus interface.

---
 rtl/acc_store_unit_pkg.sv | 16 +
 rtl/acc_store_unit.sv | 135 +++++++++++++
 tb/tb_acc_store_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/acc_store_unit_pkg.sv
// Shared definitions for the accumulator write-back path: state encoding and
// default bus widths used alongside the accumulator, ALU and address mux.
package acc_store_unit_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 13;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StStrobe = 3'd2,
        StHold   = 3'd3,
        StDone   = 3'd4
    } store_state_e;

endpackage

// File: rtl/acc_store_unit.sv
// Accumulator store unit: captures the accumulator and target address on a store
// request and runs a timed write cycle (setup, strobe with minimum width and ack
// wait, hold, completion pulse). Every output comes straight from a flop.
module acc_store_unit
    import acc_store_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned WR_HOLD = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] acc_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_data_oe,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_HOLD_LAST    = CNT_W'(WR_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    store_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              oe_q, oe_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State, counter, captured operands and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            oe_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            oe_q    <= oe_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, strobe counter, operand capture and sticky timeout flag
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = addr_in;
                    data_d  = acc_in;
                    err_d   = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StStrobe;
            end
            StStrobe: begin
                // An ack seen before the minimum strobe width has elapsed is ignored
                if (cnt_q >= CNT_HOLD_LAST && mem_ack) begin
                    state_d = StHold;
                end else if (cnt_q == CNT_TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the next state so they are registered alongside it
    always_comb begin
        oe_d   = 1'b0;
        wr_d   = 1'b0;
        busy_d = (state_d != StIdle);
        done_d = 1'b0;
        unique case (state_d)
            StSetup:  oe_d = 1'b1;
            StStrobe: begin
                oe_d = 1'b1;
                wr_d = 1'b1;
            end
            StHold:   oe_d = 1'b1;
            StDone:   done_d = 1'b1;
            default:  ;
        endcase
    end

    assign mem_addr     = addr_q;
    assign mem_data_out = data_q;
    assign mem_data_oe  = oe_q;
    assign mem_wr       = wr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_acc_store_unit.sv
// Bench for acc_store_unit: table of store scenarios driven through one task,
// completions checked against a scoreboard queue, plus reset corner sequences.
module tb_acc_store_unit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] acc_in;
    logic [ADDR_W-1:0] addr_in;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_oe;
    logic              mem_wr;
    logic              busy;
    logic              done;
    logic              err;

    acc_store_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .WR_HOLD(2),
        .TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .acc_in      (acc_in),
        .addr_in     (addr_in),
        .mem_ack     (mem_ack),
        .mem_addr    (mem_addr),
        .mem_data_out(mem_data_out),
        .mem_data_oe (mem_data_oe),
        .mem_wr      (mem_wr),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        int                ack_from;  // 0-based strobe cycle from which ack is high, -1 never
        bit                pulse0;    // ack also high in the first strobe cycle
        bit                poke;      // fire a rejected start during the strobe
        int                exp_wr;    // expected strobe width in cycles
        bit                exp_err;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              e;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_stores = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Completion monitor: each done pulse must match the oldest outstanding store
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk("done_unexpected", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_addr", 32'(mem_addr), 32'(e.a));
                chk("sb_data", 32'(mem_data_out), 32'(e.d));
                chk("sb_err", 32'(err), 32'(e.e));
            end
        end
    end

    task automatic do_store(input vec_t v);
        int  wr_cnt;
        bit  ended;
        exp_t e;
        wr_cnt  = 0;
        ended   = 1'b0;
        acc_in  = v.d;
        addr_in = v.a;
        start   = 1'b1;
        mem_ack = (v.ack_from == 0);
        e.a = v.a;
        e.d = v.d;
        e.e = v.exp_err;
        sb_q.push_back(e);
        n_stores++;
        @(negedge clk);
        start = 1'b0;
        chk("setup_busy", 32'(busy), 32'd1);
        chk("setup_oe", 32'(mem_data_oe), 32'd1);
        chk("setup_wr", 32'(mem_wr), 32'd0);
        chk("setup_err", 32'(err), 32'd0);
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (!mem_wr) begin
                ended = 1'b1;
                break;
            end
            wr_cnt++;
            mem_ack = (v.ack_from >= 0 && wr_cnt - 1 >= v.ack_from) || (v.pulse0 && wr_cnt == 1);
            start   = v.poke && wr_cnt == 1;
            if (start) begin
                acc_in  = 8'h3C;
                addr_in = 13'h1FFF;
            end
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        chk("strobe_ended", 32'(ended), 32'd1);
        chk("wr_width", 32'(wr_cnt), 32'(v.exp_wr));
        chk("hold_oe", 32'(mem_data_oe), 32'd1);
        chk("hold_done", 32'(done), 32'd0);
        chk("hold_addr", 32'(mem_addr), 32'(v.a));
        chk("hold_data", 32'(mem_data_out), 32'(v.d));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_oe", 32'(mem_data_oe), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_err", 32'(err), 32'(v.exp_err));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_addr", 32'(mem_addr), 32'(v.a));
        chk("idle_data", 32'(mem_data_out), 32'(v.d));
        if (v.exp_err) begin
            repeat (3) @(negedge clk);
            chk("err_sticky", 32'(err), 32'd1);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vec_t vr;
        bit   got_wr;
        vecs[0] = '{d: 8'hA5, a: 13'h0123, ack_from: 0,  pulse0: 1'b0, poke: 1'b0,
                    exp_wr: 2,  exp_err: 1'b0};
        vecs[1] = '{d: 8'h5A, a: 13'h1ABC, ack_from: 5,  pulse0: 1'b0, poke: 1'b0,
                    exp_wr: 6,  exp_err: 1'b0};
        vecs[2] = '{d: 8'hC3, a: 13'h0F0F, ack_from: 3,  pulse0: 1'b1, poke: 1'b0,
                    exp_wr: 4,  exp_err: 1'b0};
        vecs[3] = '{d: 8'h81, a: 13'h1000, ack_from: -1, pulse0: 1'b0, poke: 1'b0,
                    exp_wr: 16, exp_err: 1'b1};
        vecs[4] = '{d: 8'hA5, a: 13'h0456, ack_from: 0,  pulse0: 1'b0, poke: 1'b1,
                    exp_wr: 2,  exp_err: 1'b0};

        rst     = 1'b1;
        start   = 1'b0;
        acc_in  = '0;
        addr_in = '0;
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data_out), 32'd0);
        chk("rst_oe", 32'(mem_data_oe), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) do_store(vecs[i]);

        // Reset in the middle of a strobe drops the store without a done pulse
        acc_in  = 8'h77;
        addr_in = 13'h0AAA;
        start   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        got_wr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_wr) begin
                got_wr = 1'b1;
                break;
            end
        end
        chk("mid_wr_seen", 32'(got_wr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wr", 32'(mem_wr), 32'd0);
        chk("midrst_oe", 32'(mem_data_oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_data", 32'(mem_data_out), 32'd0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
        end

        vr = '{d: 8'h69, a: 13'h0321, ack_from: 0, pulse0: 1'b0, poke: 1'b0,
               exp_wr: 2, exp_err: 1'b0};
        do_store(vr);

        chk("done_count", 32'(n_done), 32'(n_stores));
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
